// File: rtl/mem_io_ctrl_if.sv
// CPU-side command/response bus of the memory/IO controller.
interface mem_io_ctrl_if #(
    parameter int DW = 16
);
    logic [1:0]    mem_cmd;
    logic [8:0]    mem_addr;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
    logic          ready;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, ready
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/mem_io_ctrl.sv
// Memory/IO controller: RAM window, LED register and switch port on a 9-bit word bus.
// Defining HEX_REG_EN adds the hex display register at 0x180 and the hex_val port.
module mem_io_ctrl #(
    parameter int DW     = 16,
    parameter int RAM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_io_ctrl_if.slave      cpu,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_write,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout,
    input  logic [9:0]        sw,
    output logic [7:0]        ledr
`ifdef HEX_REG_EN
    ,
    output logic [DW-1:0]     hex_val
`endif
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state, state_n;

    logic          cmd_rd, cmd_wr;
    logic          hit_ram, hit_led, hit_sw;
    logic [9:0]    sw_s1, sw_s2;
    logic [DW-1:0] rd_q, rd_d, io_rd;
    logic          rd_ld, rdy_q, rdy_d, led_ld;
`ifdef HEX_REG_EN
    logic          hit_hex, hex_ld;
`endif

    assign cmd_rd  = cpu.mem_cmd == 2'b01;
    assign cmd_wr  = cpu.mem_cmd == 2'b10;
    assign hit_ram = (cpu.mem_addr >> RAM_AW) == '0;
    assign hit_led = cpu.mem_addr == 9'h100;
    assign hit_sw  = cpu.mem_addr == 9'h140;
`ifdef HEX_REG_EN
    assign hit_hex = cpu.mem_addr == 9'h180;
`endif

    assign ram_addr      = cpu.mem_addr[RAM_AW-1:0];
    assign ram_din       = cpu.write_data;
    assign cpu.read_data = rd_q;
    assign cpu.ready     = rdy_q;

    // Non-RAM read sources; anything not decoded reads as zero.
    always_comb begin
        io_rd = '0;
        unique case (1'b1)
            hit_sw:  io_rd = DW'(sw_s2);
`ifdef HEX_REG_EN
            hit_hex: io_rd = hex_val;
`endif
            default: io_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (cmd_rd && hit_ram)  state_n = RD_WAIT;
                else if (cmd_rd || cmd_wr) state_n = DONE;
            end
            RD_WAIT: state_n = DONE;
            DONE: begin
                if (!cmd_rd && !cmd_wr) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ram_write = 1'b0;
        rdy_d     = 1'b0;
        rd_ld     = 1'b0;
        rd_d      = '0;
        led_ld    = 1'b0;
`ifdef HEX_REG_EN
        hex_ld    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                ram_write = reset && cmd_wr && hit_ram;
                if (cmd_rd && !hit_ram) begin
                    rd_ld = 1'b1;
                    rd_d  = io_rd;
                    rdy_d = 1'b1;
                end
                if (cmd_wr) begin
                    rdy_d  = 1'b1;
                    led_ld = hit_led;
`ifdef HEX_REG_EN
                    hex_ld = hit_hex;
`endif
                end
            end
            // RAM data for the address sampled in IDLE is valid now.
            RD_WAIT: begin
                rd_ld = 1'b1;
                rd_d  = ram_dout;
                rdy_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q  <= '0;
            rdy_q <= 1'b0;
            ledr  <= '0;
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            rdy_q <= rdy_d;
            if (rd_ld)  rd_q <= rd_d;
            if (led_ld) ledr <= cpu.write_data[7:0];
        end
    end

`ifdef HEX_REG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      hex_val <= '0;
        else if (hex_ld) hex_val <= cpu.write_data;
    end
`endif
endmodule

// File: tb/tb_mem_io_ctrl.sv
// Self-checking bench for mem_io_ctrl: directed table, corner sequences, random ops vs model.
module tb_mem_io_ctrl;
    localparam int DW = 16;
`ifdef HEX_REG_EN
    localparam logic [15:0] HEXV = 16'hABCD;
`else
    localparam logic [15:0] HEXV = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ram_addr;
    logic        ram_write;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [9:0]  sw;
    logic [7:0]  ledr;
`ifdef HEX_REG_EN
    logic [15:0] hex_val;
`endif

    always #5 clk = ~clk;

    mem_io_ctrl_if #(.DW(DW)) bus ();

    mem_io_ctrl #(.DW(DW), .RAM_AW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (bus.slave),
        .ram_addr  (ram_addr),
        .ram_write (ram_write),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .sw        (sw),
        .ledr      (ledr)
`ifdef HEX_REG_EN
        ,
        .hex_val   (hex_val)
`endif
    );

    // Synchronous-read RAM seen by the controller
    logic [15:0] ram [256];
    always @(posedge clk) begin
        if (ram_write) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    endtask

    // One access: drive at negedge, wait for ready (bounded), then drop cmd
    task automatic access(input logic [1:0] c, input logic [8:0] a,
                          input logic [15:0] wd, output int lat,
                          output logic wr, output logic [7:0] wa,
                          output logic [15:0] wdin, output logic after);
        @(negedge clk);
        bus.mem_cmd    = c;
        bus.mem_addr   = a;
        bus.write_data = wd;
        #1;
        wr   = ram_write;
        wa   = ram_addr;
        wdin = ram_din;
        lat  = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.ready && lat < 6);
        @(negedge clk);
        bus.mem_cmd = 2'b00;
        @(posedge clk);
        #1;
        after = bus.ready;
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wd;
        logic [15:0] rd;
        int          lat;
        logic [7:0]  led;
        logic        wr;
    } vec_t;

    vec_t tbl [10];

    // Reference model state
    logic [15:0] ref_ram [256];
    logic [7:0]  ref_led;
    logic [15:0] ref_hex;
    logic [15:0] ref_rd;

    function automatic logic [15:0] model_read(input logic [8:0] a);
        if (a < 9'h100) return ref_ram[a[7:0]];
        if (a == 9'h140) return {6'b0, sw};
`ifdef HEX_REG_EN
        if (a == 9'h180) return ref_hex;
`endif
        return 16'h0000;
    endfunction

    int          lat;
    logic        wr, after;
    logic [7:0]  wa;
    logic [15:0] wdin;
    int          n_rdy, n_wr;
    logic [1:0]  c;
    logic [8:0]  a;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    int          exp_lat;
    logic        exp_wr;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 16'h0;
            ref_ram[i] = 16'h0;
        end
        tbl[0] = '{2'b10, 9'h005, 16'hBEEF, 16'h0000, 1, 8'h00, 1'b1};
        tbl[1] = '{2'b01, 9'h005, 16'h0000, 16'hBEEF, 2, 8'h00, 1'b0};
        tbl[2] = '{2'b01, 9'h140, 16'h0000, 16'h02A5, 1, 8'h00, 1'b0};
        tbl[3] = '{2'b10, 9'h100, 16'h12C3, 16'h02A5, 1, 8'hC3, 1'b0};
        tbl[4] = '{2'b01, 9'h1FF, 16'h0000, 16'h0000, 1, 8'hC3, 1'b0};
        tbl[5] = '{2'b10, 9'h180, 16'hABCD, 16'h0000, 1, 8'hC3, 1'b0};
        tbl[6] = '{2'b01, 9'h180, 16'h0000, HEXV,     1, 8'hC3, 1'b0};
        tbl[7] = '{2'b10, 9'h0FF, 16'h1234, HEXV,     1, 8'hC3, 1'b1};
        tbl[8] = '{2'b01, 9'h0FF, 16'h0000, 16'h1234, 2, 8'hC3, 1'b0};
        tbl[9] = '{2'b10, 9'h100, 16'h00A5, 16'h1234, 1, 8'hA5, 1'b0};

        // Reset with a RAM write pending on the bus
        reset          = 1'b0;
        bus.mem_cmd    = 2'b10;
        bus.mem_addr   = 9'h005;
        bus.write_data = 16'h5555;
        sw             = 10'h0;
        #1;
        chk("rst_ram_write", ram_write, 0);
        chk("rst_read_data", bus.read_data, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_ledr", ledr, 0);
`ifdef HEX_REG_EN
        chk("rst_hex", hex_val, 0);
`endif
        repeat (2) @(negedge clk);
        bus.mem_cmd = 2'b00;
        reset       = 1'b1;

        sw = 10'h2A5;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 10; i++) begin
            access(tbl[i].cmd, tbl[i].addr, tbl[i].wd, lat, wr, wa, wdin, after);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_rd", i), bus.read_data, tbl[i].rd);
            chk($sformatf("tbl%0d_led", i), ledr, tbl[i].led);
            chk($sformatf("tbl%0d_wr", i), wr, tbl[i].wr);
            chk($sformatf("tbl%0d_pulse", i), after, 0);
            if (tbl[i].wr) begin
                chk($sformatf("tbl%0d_waddr", i), wa, tbl[i].addr[7:0]);
                chk($sformatf("tbl%0d_wdin", i), wdin, tbl[i].wd);
            end
        end
`ifdef HEX_REG_EN
        chk("hex_val", hex_val, 16'hABCD);
`endif

        // Command 11 behaves as NONE
        @(negedge clk);
        bus.mem_cmd  = 2'b11;
        bus.mem_addr = 9'h005;
        n_rdy = 0;
        n_wr  = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_wr += int'(ram_write);
            @(posedge clk);
            #1;
            n_rdy += int'(bus.ready);
            @(negedge clk);
        end
        bus.mem_cmd = 2'b00;
        chk("cmd11_ready", n_rdy, 0);
        chk("cmd11_wr", n_wr, 0);

        // RAM write held for 5 cycles executes once
        bus.mem_cmd    = 2'b10;
        bus.mem_addr   = 9'h010;
        bus.write_data = 16'h7E57;
        n_rdy = 0;
        n_wr  = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_wr += int'(ram_write);
            @(posedge clk);
            #1;
            n_rdy += int'(bus.ready);
            @(negedge clk);
        end
        bus.mem_cmd = 2'b00;
        chk("held_ready", n_rdy, 1);
        chk("held_wr", n_wr, 1);
        access(2'b01, 9'h010, 16'h0, lat, wr, wa, wdin, after);
        chk("held_readback", bus.read_data, 16'h7E57);

        // Reset pulsed during RD_WAIT
        @(negedge clk);
        bus.mem_cmd  = 2'b01;
        bus.mem_addr = 9'h0FF;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_rd", bus.read_data, 0);
        chk("mid_rst_led", ledr, 0);
        chk("mid_rst_ready", bus.ready, 0);
        @(negedge clk);
        bus.mem_cmd  = 2'b10;
        bus.mem_addr = 9'h030;
        #1;
        chk("mid_rst_ram_write", ram_write, 0);
        @(negedge clk);
        bus.mem_cmd = 2'b00;
        reset       = 1'b1;
        n_rdy = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            n_rdy += int'(bus.ready);
        end
        chk("mid_rst_no_pulse", n_rdy, 0);
        access(2'b10, 9'h100, 16'h0077, lat, wr, wa, wdin, after);
        chk("post_rst_lat", lat, 1);
        chk("post_rst_led", ledr, 8'h77);
        chk("post_rst_rd", bus.read_data, 0);

        // Random operations against the model
        ref_led = 8'h77;
        ref_hex = 16'h0;
        ref_rd  = 16'h0;
        for (int i = 0; i < 200; i++) begin
            c  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            wd = 16'($urandom());
            case ($urandom_range(0, 5))
                0, 1:    a = 9'h040 + 9'($urandom_range(0, 15));
                2:       a = 9'h100;
                3:       a = 9'h140;
                4:       a = 9'h180;
                default: a = 9'h100 + 9'($urandom_range(1, 255));
            endcase
            if (c == 2'b01 && a == 9'h140) begin
                sw = 10'($urandom());
                repeat (3) @(posedge clk);
            end
            if (c == 2'b01) begin
                exp_rd  = model_read(a);
                exp_lat = (a < 9'h100) ? 2 : 1;
                exp_wr  = 1'b0;
                ref_rd  = exp_rd;
            end else begin
                exp_rd  = ref_rd;
                exp_lat = 1;
                exp_wr  = a < 9'h100;
                if (a < 9'h100) ref_ram[a[7:0]] = wd;
                if (a == 9'h100) ref_led = wd[7:0];
`ifdef HEX_REG_EN
                if (a == 9'h180) ref_hex = wd;
`endif
            end
            access(c, a, wd, lat, wr, wa, wdin, after);
            chk($sformatf("rnd%0d_lat a=%h", i, a), lat, exp_lat);
            chk($sformatf("rnd%0d_rd a=%h", i, a), bus.read_data, exp_rd);
            chk($sformatf("rnd%0d_led", i), ledr, ref_led);
            chk($sformatf("rnd%0d_wr a=%h", i, a), wr, exp_wr);
            chk($sformatf("rnd%0d_pulse", i), after, 0);
            if (exp_wr) chk($sformatf("rnd%0d_wdin", i), wdin, wd);
        end
`ifdef HEX_REG_EN
        chk("rnd_hex", hex_val, ref_hex);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 Parameter DW, default 16, data word width.
REQ-002 Parameter RAM_AW, default 8, RAM address width (256 words).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 mem_cmd  in  2  CPU command: 00 NONE, 01 READ, 10 WRITE, 11 treated as NONE.
REQ-006 mem_addr  in  9  CPU word address.
REQ-007 write_data  in  DW  CPU store data.
REQ-008 read_data  out  DW  load data returned to CPU (registered).
REQ-009 ready  out  1  one-cycle pulse; access complete.
REQ-010 ram_addr  out  RAM_AW  RAM address, = mem_addr[RAM_AW-1:0].
REQ-011 ram_write  out  1  RAM write enable, one cycle per store.
REQ-012 ram_din  out  DW  RAM write data, = write_data.
REQ-013 ram_dout  in  DW  RAM read data, valid one cycle after address.
REQ-014 sw  in  10  board switches (asynchronous).
REQ-015 ledr  out  8  LED output register.
REQ-016 hex_val  out  DW  hex display register (present only with HEX_REG_EN).

Function
REQ-017 Map: 0x000-0x0FF RAM; 0x100 LED register (write); 0x140 switches (read); 0x180 hex register (write, HEX_REG_EN); all else unmapped.
REQ-018 FSM states IDLE, RD_WAIT, DONE.
REQ-019 IDLE + READ to RAM -> RD_WAIT; next edge: read_data <= ram_dout, ready=1, -> DONE (RAM read latency 2 cycles from cmd sample).
REQ-020 IDLE + READ to 0x140 -> read_data <= {6'b0, sw_sync}, ready=1 next cycle, -> DONE.
REQ-021 IDLE + READ unmapped -> read_data <= 0, ready=1 next cycle, -> DONE.
REQ-022 IDLE + WRITE to RAM -> ram_write=1 for exactly that cycle (combinational from IDLE+WRITE+RAM decode), ready=1 next cycle, -> DONE.
REQ-023 IDLE + WRITE to 0x100 -> ledr <= write_data[7:0], ready=1 next cycle, -> DONE.
REQ-024 IDLE + WRITE unmapped -> no state change besides ready=1 next cycle, -> DONE.
REQ-025 DONE: ready=0; stay until mem_cmd = NONE, then -> IDLE; a held command never re-executes.
REQ-026 Changes to mem_cmd/mem_addr while in RD_WAIT are ignored; the sampled access completes.
REQ-027 sw passes a 2-flop synchronizer; sw_sync lags sw by 2 edges.
REQ-028 ram_write=0 in every state except IDLE with a RAM-decoded WRITE.
REQ-029 read_data holds its value between reads; writes do not alter it.

Reset
REQ-030 reset=0 forces immediately: state IDLE, read_data=0, ready=0, ledr=0, hex_val=0, synchronizer flops=0.
REQ-031 Reset mid-access (RD_WAIT or DONE) aborts it; no ready pulse is issued for that access.
REQ-032 ram_write=0 while reset asserted.

Configuration
REQ-033 Macro HEX_REG_EN defined: port hex_val and register at 0x180 exist; WRITE to 0x180 sets hex_val <= write_data; READ of 0x180 returns hex_val.
REQ-034 Macro HEX_REG_EN undefined: no hex_val port; 0x180 behaves as unmapped.

Verification
REQ-035 Reset released, WRITE 0x005 data 0xBEEF -> ram_write=1 one cycle, ram_addr=0x05, ram_din=0xBEEF, ready pulse next cycle.
REQ-036 READ 0x005 with RAM model returning 0xBEEF -> ready pulse 2 cycles after cmd, read_data=0xBEEF.
REQ-037 sw=10'h2A5, wait 3 cycles, READ 0x140 -> read_data=0x02A5.
REQ-038 WRITE 0x100 data 0x12C3 -> ledr=0xC3; READ 0x1FF -> read_data=0x0000; WRITE held 5 cycles -> exactly one ready pulse.
REQ-039 HEX_REG_EN defined: WRITE 0x180 data 0xABCD -> hex_val=0xABCD, READ 0x180 -> 0xABCD; undefined: READ 0x180 -> 0x0000.
REQ-040 reset pulsed low during RD_WAIT -> no ready pulse, read_data=0, ledr=0, state IDLE.
